led_period_mon: RTL and testbench

- Receive-side companion to the LED counter/blinker.
- Samples a square-wave LED signal and measures the interval between consecutive edges in clk100 cycles.
- Reports the measured half-period, a log2 divider estimate, a lock indicator and a stall flag.
- Used on the PL side to check blinker output, in loopback from the blinker's led_o, or from a pin for bring-up.

---
 rtl/led_period_mon_if.sv | 30 +++
 rtl/led_period_mon.sv | 177 +++++++++++++++++
 tb/tb_led_period_mon.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_period_mon_if.sv
// Bundles the LED input, the synchronous clear and the measurement results of led_period_mon.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; the results are level outputs plus a one-cycle valid_o pulse.
// Ports: led_i, clr_i          - waveform under test and synchronous clear (master -> slave)
//        period_o, div_o       - last edge-to-edge interval and its floor(log2) (slave -> master)
//        valid_o, lock_o       - update pulse and lock indicator (slave -> master)
//        stall_o               - no edge seen for TIMEOUT cycles (slave -> master)
interface led_period_mon_if #(
    parameter int CNT_W = 32
);
    logic             led_i;
    logic             clr_i;
    logic [CNT_W-1:0] period_o;
    logic [4:0]       div_o;
    logic             valid_o;
    logic             lock_o;
    logic             stall_o;

    // master: whoever drives the LED and reads the results (bench, checker logic)
    modport master (
        output led_i, clr_i,
        input  period_o, div_o, valid_o, lock_o, stall_o
    );

    // slave: the period monitor itself
    modport slave (
        input  led_i, clr_i,
        output period_o, div_o, valid_o, lock_o, stall_o
    );
endinterface

// File: rtl/led_period_mon.sv
// Measures the edge-to-edge interval of a square-wave LED signal in clk100 cycles; reports period, log2 divider, lock and stall.
// Latency: valid_o 2 cycles after the closing led_i transition (4 with LED_PERIOD_MON_SYNC_EN defined).
// Backpressure: none; results are registered levels and valid_o is a single-cycle pulse with no ready.
// Optional macro LED_PERIOD_MON_SYNC_EN: adds a 2-flop synchronizer so led_i may come straight from a pin.
// Ports: clk100, rstn (async active-low) as scalars; led_i/clr_i/period_o/div_o/valid_o/lock_o/stall_o via mon (slave).
module led_period_mon #(
    parameter int          CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 2**28,
    parameter int          LOCK_CNT  = 4,
    parameter int          TOL_SHIFT = 4
) (
    input  logic            clk100,
    input  logic            rstn,
    led_period_mon_if.slave mon
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

    typedef enum logic {WAIT_EDGE = 1'b0, MEASURE = 1'b1} state_t;

    // ---------------- input conditioning and edge detect ----------------
    logic led_pre;

`ifdef LED_PERIOD_MON_SYNC_EN
    (* ASYNC_REG = "TRUE" *) logic [1:0] led_sync;
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) led_sync <= 2'b00;
        else       led_sync <= {led_sync[0], mon.led_i};
    end
    assign led_pre = led_sync[1];
`else
    assign led_pre = mon.led_i;
`endif

    logic led_s, led_s_d;
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            led_s   <= 1'b0;
            led_s_d <= 1'b0;
        end else begin
            led_s   <= led_pre;
            led_s_d <= led_s;
        end
    end

    logic edge_det;
    assign edge_det = led_s ^ led_s_d;

    // ---------------- state and measurement registers ----------------
    state_t           state_q,   state_nxt;
    logic [CNT_W-1:0] cnt_q,     cnt_nxt;
    logic [CNT_W-1:0] period_q,  period_nxt;
    logic [4:0]       div_q,     div_nxt;
    logic             valid_q,   valid_nxt;
    logic             lock_q,    lock_nxt;
    logic             stall_q,   stall_nxt;
    logic [3:0]       match_q,   match_nxt;
    // period_q only counts as a reference once a measurement has been taken since the last WAIT_EDGE
    logic             have_prev_q, have_prev_nxt;

    function automatic logic [4:0] msb_index(input logic [CNT_W-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    // Tolerance check against the previous period; one extra bit keeps the subtraction unsigned-safe.
    logic [CNT_W:0] cnt_ext, per_ext, diff, tol;
    logic           is_match;
    logic [3:0]     match_inc;
    always_comb begin
        cnt_ext   = {1'b0, cnt_q};
        per_ext   = {1'b0, period_q};
        diff      = (cnt_ext >= per_ext) ? (cnt_ext - per_ext) : (per_ext - cnt_ext);
        tol       = {1'b0, period_q >> TOL_SHIFT};
        is_match  = have_prev_q && (diff <= tol);
        match_inc = (match_q >= LOCK_C) ? LOCK_C : (match_q + 4'd1);
    end

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        period_nxt    = period_q;
        div_nxt       = div_q;
        valid_nxt     = 1'b0;
        lock_nxt      = lock_q;
        stall_nxt     = stall_q;
        match_nxt     = match_q;
        have_prev_nxt = have_prev_q;

        if (mon.clr_i) begin
            state_nxt     = WAIT_EDGE;
            cnt_nxt       = '0;
            period_nxt    = '0;
            div_nxt       = '0;
            lock_nxt      = 1'b0;
            stall_nxt     = 1'b0;
            match_nxt     = '0;
            have_prev_nxt = 1'b0;
        end else begin
            case (state_q)
                WAIT_EDGE: begin
                    cnt_nxt = '0;
                    // First edge only (re)starts timing; it clears a pending stall but yields no result.
                    if (edge_det) begin
                        cnt_nxt       = CNT_W'(1);
                        stall_nxt     = 1'b0;
                        have_prev_nxt = 1'b0;
                        state_nxt     = MEASURE;
                    end
                end
                MEASURE: begin
                    // Edge is tested before timeout so an interval of exactly TIMEOUT is still measured.
                    if (edge_det) begin
                        period_nxt    = cnt_q;
                        div_nxt       = msb_index(cnt_q);
                        valid_nxt     = 1'b1;
                        cnt_nxt       = CNT_W'(1);
                        have_prev_nxt = 1'b1;
                        if (is_match) begin
                            match_nxt = match_inc;
                            lock_nxt  = (match_inc == LOCK_C);
                        end else begin
                            match_nxt = '0;
                            lock_nxt  = 1'b0;
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        stall_nxt     = 1'b1;
                        lock_nxt      = 1'b0;
                        match_nxt     = '0;
                        cnt_nxt       = '0;
                        have_prev_nxt = 1'b0;
                        state_nxt     = WAIT_EDGE;
                    end else if (cnt_q != '1) begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                default: state_nxt = WAIT_EDGE;
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state_q     <= WAIT_EDGE;
            cnt_q       <= '0;
            period_q    <= '0;
            div_q       <= '0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            stall_q     <= 1'b0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            period_q    <= period_nxt;
            div_q       <= div_nxt;
            valid_q     <= valid_nxt;
            lock_q      <= lock_nxt;
            stall_q     <= stall_nxt;
            match_q     <= match_nxt;
            have_prev_q <= have_prev_nxt;
        end
    end

    assign mon.period_o = period_q;
    assign mon.div_o    = div_q;
    assign mon.valid_o  = valid_q;
    assign mon.lock_o   = lock_q;
    assign mon.stall_o  = stall_q;

endmodule

// File: tb/tb_led_period_mon.sv
// Directed bench for led_period_mon: table of LED intervals with hand-computed period/div/lock,
// plus hand-written sequences for stall, edge-at-timeout, async reset, clear and one-cycle toggling.
// Every valid_o pulse is matched in order against an expected queue filled by the stimulus.
module tb_led_period_mon;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 5000;
`ifdef LED_PERIOD_MON_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = 2 + SYNC;

    logic clk;
    logic rstn;
    int   cyc;
    int   last_tog;
    int   total;
    int   bad;

    led_period_mon_if #(.CNT_W(CNT_W)) bus ();

    led_period_mon #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .LOCK_CNT (4),
        .TOL_SHIFT(4)
    ) dut (
        .clk100 (clk),
        .rstn   (rstn),
        .mon    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] period;
        logic [4:0]  div;
        logic        lock;
        int          at;
    } exp_t;

    typedef struct {
        int          gap;
        logic [31:0] period;
        logic [4:0]  div;
        logic        lock;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur_e;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // In-order check of every valid_o pulse against what the stimulus promised.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.valid_o !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid_o=%b period=%0d expected no pulse (cycle %0d)",
                         bus.valid_o, bus.period_o, cyc);
            end else begin
                cur_e = exp_q.pop_front();
                chk("valid_cycle", 64'(cyc), 64'(cur_e.at));
                chk("period_o", 64'(bus.period_o), 64'(cur_e.period));
                chk("div_o", 64'(bus.div_o), 64'(cur_e.div));
                chk("lock_o", 64'(bus.lock_o), 64'(cur_e.lock));
            end
        end
    end

    // Resume #1 after the posedge at which cyc reaches target.
    task automatic wait_after(input int target);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < target);
    endtask

    task automatic wait_neg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic toggle_only(input int gap);
        wait_after(last_tog + gap);
        bus.led_i = ~bus.led_i;
        last_tog  = cyc;
    endtask

    task automatic toggle_expect(input int gap, input logic [31:0] p, input logic [4:0] d, input logic l);
        exp_t e;
        toggle_only(gap);
        e.period = p;
        e.div    = d;
        e.lock   = l;
        e.at     = last_tog + LAT;
        exp_q.push_back(e);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_period"}, 64'(bus.period_o), 64'd0);
        chk({tag, "_div"},    64'(bus.div_o),    64'd0);
        chk({tag, "_valid"},  64'(bus.valid_o),  64'd0);
        chk({tag, "_lock"},   64'(bus.lock_o),   64'd0);
        chk({tag, "_stall"},  64'(bus.stall_o),  64'd0);
    endtask

    initial begin
        int t;
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        bus.led_i = 1'b0;
        bus.clr_i = 1'b0;

        // 1000-cycle toggling: lock on the 5th result; 1070 breaks lock (tol 62),
        // the next 1000 also misses (tol 1070>>4=66), relock 4 matches later; 1060 stays within tol 62.
        vecs[0]  = '{1000, 1000,  9, 1'b0};
        vecs[1]  = '{1000, 1000,  9, 1'b0};
        vecs[2]  = '{1000, 1000,  9, 1'b0};
        vecs[3]  = '{1000, 1000,  9, 1'b0};
        vecs[4]  = '{1000, 1000,  9, 1'b1};
        vecs[5]  = '{1070, 1070, 10, 1'b0};
        vecs[6]  = '{1000, 1000,  9, 1'b0};
        vecs[7]  = '{1000, 1000,  9, 1'b0};
        vecs[8]  = '{1000, 1000,  9, 1'b0};
        vecs[9]  = '{1000, 1000,  9, 1'b0};
        vecs[10] = '{1000, 1000,  9, 1'b1};
        vecs[11] = '{1060, 1060, 10, 1'b1};
        vecs[12] = '{1000, 1000,  9, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rstn     = 1'b1;
        last_tog = cyc;

        toggle_only(5);
        for (int i = 0; i < 13; i++) begin
            toggle_expect(vecs[i].gap, vecs[i].period, vecs[i].div, vecs[i].lock);
        end

        // Hold led_i: stall appears exactly where a TIMEOUT-long interval would have reported.
        t = last_tog;
        wait_neg(t + TIMEOUT + LAT - 1);
        chk("stall_before_timeout", 64'(bus.stall_o), 64'd0);
        chk("lock_before_timeout", 64'(bus.lock_o), 64'd1);
        @(negedge clk);
        chk("stall_at_timeout", 64'(bus.stall_o), 64'd1);
        chk("lock_at_timeout", 64'(bus.lock_o), 64'd0);

        // First edge after stall only restarts timing and clears stall.
        toggle_only(TIMEOUT + LAT + 50);
        wait_neg(last_tog + LAT - 1);
        chk("stall_held_until_edge", 64'(bus.stall_o), 64'd1);
        @(negedge clk);
        chk("stall_cleared", 64'(bus.stall_o), 64'd0);

        // Edge coinciding with cnt==TIMEOUT: measured, not a stall.
        toggle_expect(TIMEOUT, 32'(TIMEOUT), 5'd12, 1'b0);
        wait_neg(last_tog + LAT + 2);
        chk("stall_edge_wins", 64'(bus.stall_o), 64'd0);
        toggle_expect(300, 300, 8, 1'b0);

        // Async reset mid-interval.
        wait_neg(last_tog + LAT + 3);
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        bus.led_i = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rstn     = 1'b1;
        last_tog = cyc;
        toggle_only(10);
        toggle_expect(200, 200, 7, 1'b0);

        // clr_i in MEASURE, landing on the same cycle as an edge: clear wins, no result.
        wait_neg(last_tog + LAT + 3);
        toggle_only(100);
        repeat (1 + SYNC) @(posedge clk);
        #1;
        bus.clr_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_i = 1'b0;
        chk_idle_outputs("clr");
        toggle_only(20);
        toggle_expect(150, 150, 7, 1'b0);

        // Clear, then toggle every cycle: period 1 each cycle, lock from the 5th result.
        wait_neg(last_tog + LAT + 3);
        @(posedge clk);
        #1;
        bus.clr_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_i = 1'b0;
        toggle_only(5);
        for (int k = 1; k <= 12; k++) begin
            toggle_expect(1, 1, 0, (k >= 5));
        end

        wait_neg(last_tog + LAT + 3);
        chk("pending_valids", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
